ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter N_PORTS, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter WIDTH, default 32: data width; it SHALL match the shared RAM.
REQ-003 Parameter DEPTH, default 8: RAM entries; AW = $clog2(DEPTH).
REQ-004 clock  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_read_valid  input  N_PORTS  per-port read request.
REQ-007 req_read_ready  output  N_PORTS  one-hot read grant.
REQ-008 req_read_address  input  N_PORTS x AW  per-port read address.
REQ-009 rsp_read_valid  output  N_PORTS  one-hot read-data strobe.
REQ-010 rsp_read_data  output  WIDTH  read data, shared by all ports.
REQ-011 req_write_valid  input  N_PORTS  per-port write request.
REQ-012 req_write_ready  output  N_PORTS  one-hot write grant.
REQ-013 req_write_address  input  N_PORTS x AW  per-port write address.
REQ-014 req_write_data  input  N_PORTS x WIDTH  per-port write data.
REQ-015 ram_read_vaild, ram_read_address  output  1, AW  RAM read port drive.
REQ-016 ram_read_data  input  WIDTH  RAM registered read data (1-cycle latency; undriven when not read).
REQ-017 ram_write_vaild, ram_write_address, ram_write_data  output  1, AW, WIDTH  RAM write port drive.

Function
REQ-018 Read and write paths SHALL be arbitrated independently; each grants at most one port per cycle.
REQ-019 Each path SHALL use round-robin: after a grant to port i, priority order is i+1, i+2, ..., wrapping modulo N_PORTS, with i lowest.
REQ-020 The round-robin pointer SHALL advance only in cycles where a grant is issued; an idle cycle leaves it unchanged.
REQ-021 Grants (req_*_ready) SHALL be combinational from the current requests and pointer; a transfer occurs when valid and ready are both high.
REQ-022 A requester SHALL hold valid, address and data stable until ready; the arbiter SHALL NOT require the requester to drop valid after a grant.
REQ-023 A granted read SHALL drive ram_read_vaild=1 and the granted address in the same cycle; otherwise ram_read_vaild=0 and address=0.
REQ-024 rsp_read_valid[i] SHALL be 1 exactly one cycle after a read grant to port i, with rsp_read_data equal to ram_read_data in that cycle.
REQ-025 rsp_read_data SHALL be 0 whenever no rsp_read_valid bit is set; undriven RAM data SHALL never propagate.
REQ-026 A granted write SHALL drive ram_write_vaild=1 with the granted address and data in the same cycle; otherwise all write outputs are 0.
REQ-027 A read and a write to the same address granted in the same cycle SHALL return the old data; the new data is visible to reads granted from the next cycle.
REQ-028 Back-to-back reads SHALL sustain one grant per cycle; the response register SHALL update every cycle.
REQ-029 A continuously requesting port SHALL be granted within N_PORTS cycles on its path.

Reset
REQ-030 While reset is high: all ready, rsp_read_valid, ram_*_vaild outputs = 0; rsp_read_data = 0; both pointers select port 0 as highest priority.
REQ-031 A read granted in the cycle reset asserts SHALL produce no response; no grant is issued while reset is high.
REQ-032 On the first clock after reset deasserts, arbitration SHALL resume from port 0 priority.

Structure
REQ-033 Package ram_arbiter_pkg SHALL hold the default parameter constants and the port-index typedef (logic [$clog2(N_PORTS)-1:0]).
REQ-034 Sub-module rr_arbiter (parameter N; request in, one-hot grant out, pointer register, advance-on-grant) SHALL be instantiated twice: read and write.
REQ-035 The RAM SHALL NOT be instantiated inside this block; it connects at the top level.

Verification
REQ-036 Ports 0..3 each issue one read to addresses 1..4 (RAM preloaded 0xA1..0xA4) -> grants 0,1,2,3 on consecutive cycles; rsp to port k one cycle later carries 0xA(k+1).
REQ-037 All 4 ports hold write_valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each port granted exactly twice.
REQ-038 Pointer after grant to port 2; ports 1 and 3 request -> port 3 granted first, port 1 next cycle.
REQ-039 Same cycle: port 0 writes 0x55 to addr 5 (old 0x11), port 1 reads addr 5 -> port 1 receives 0x11; read on following cycle returns 0x55.
REQ-040 Read granted to port 2, reset asserted before next edge -> rsp_read_valid stays 0; after release, first grant goes to lowest-index requester.
REQ-041 No requests for 10 cycles -> all ram_*_vaild = 0 and rsp_read_data = 0 throughout; pointers unchanged.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the RAM port arbiter slice.
package ram_arbiter_pkg;
  localparam int N_PORTS_DEF = 4;
  localparam int WIDTH_DEF   = 32;
  localparam int DEPTH_DEF   = 8;

  typedef logic [$clog2(N_PORTS_DEF)-1:0] port_idx_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from requests, pointer to last winner moves only on a grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] request,
  output logic [N-1:0] grant
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last_q, last_d;
  logic [N-1:0]  hi_mask, masked, pick;
  logic          found;

  // Ports above the last winner get first chance; otherwise wrap to the lowest requester.
  always_comb begin
    hi_mask = '0;
    for (int p = 0; p < N; p++) hi_mask[p] = (IW'(p) > last_q);
    masked = request & hi_mask;
    pick   = (|masked) ? masked : request;
    grant  = '0;
    last_d = last_q;
    found  = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (pick[p] && !found) begin
        found    = 1'b1;
        grant[p] = 1'b1;
        last_d   = IW'(p);
      end
    end
    if (reset) begin
      grant  = '0;
      last_d = last_q;
    end
  end

  // Reset value N-1 makes port 0 the highest priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_q <= IW'(N - 1);
    else       last_q <= last_d;
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Independent round-robin read and write arbitration onto one external RAM.
// Read data returns one cycle after the grant and is forced to zero when no response is due.
module ram_port_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int  N_PORTS = N_PORTS_DEF,
  parameter int  WIDTH   = WIDTH_DEF,
  parameter int  DEPTH   = DEPTH_DEF,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N_PORTS-1:0]             req_read_valid,
  output logic [N_PORTS-1:0]             req_read_ready,
  input  logic [N_PORTS-1:0][AW-1:0]     req_read_address,
  output logic [N_PORTS-1:0]             rsp_read_valid,
  output logic [WIDTH-1:0]               rsp_read_data,
  input  logic [N_PORTS-1:0]             req_write_valid,
  output logic [N_PORTS-1:0]             req_write_ready,
  input  logic [N_PORTS-1:0][AW-1:0]     req_write_address,
  input  logic [N_PORTS-1:0][WIDTH-1:0]  req_write_data,
  output logic                           ram_read_vaild,
  output logic [AW-1:0]                  ram_read_address,
  input  logic [WIDTH-1:0]               ram_read_data,
  output logic                           ram_write_vaild,
  output logic [AW-1:0]                  ram_write_address,
  output logic [WIDTH-1:0]               ram_write_data
);
  logic [N_PORTS-1:0] rd_gnt, wr_gnt, rsp_vld_q;

  rr_arbiter #(.N(N_PORTS)) u_rd_arb (
    .clock   (clock),
    .reset   (reset),
    .request (req_read_valid),
    .grant   (rd_gnt)
  );

  rr_arbiter #(.N(N_PORTS)) u_wr_arb (
    .clock   (clock),
    .reset   (reset),
    .request (req_write_valid),
    .grant   (wr_gnt)
  );

  assign req_read_ready  = rd_gnt;
  assign req_write_ready = wr_gnt;
  assign ram_read_vaild  = |rd_gnt;
  assign ram_write_vaild = |wr_gnt;

  // One-hot AND-OR muxes leave every RAM drive at zero when nothing is granted.
  always_comb begin
    ram_read_address  = '0;
    ram_write_address = '0;
    ram_write_data    = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      ram_read_address  |= req_read_address[p]  & {AW{rd_gnt[p]}};
      ram_write_address |= req_write_address[p] & {AW{wr_gnt[p]}};
      ram_write_data    |= req_write_data[p]    & {WIDTH{wr_gnt[p]}};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rsp_vld_q <= '0;
    else       rsp_vld_q <= rd_gnt;
  end

  // RAM output is undefined in cycles without a read, so gate it.
  assign rsp_read_valid = rsp_vld_q;
  assign rsp_read_data  = (|rsp_vld_q) ? ram_read_data : '0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench: a round-robin reference model predicts grants and read data; a monitor checks responses.
module tb_ram_port_arbiter;
  localparam int NP = ram_arbiter_pkg::N_PORTS_DEF;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AW = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NP-1:0]         rd_v = '0, wr_v = '0;
  logic [NP-1:0][AW-1:0] rd_a = '0, wr_a = '0;
  logic [NP-1:0][W-1:0]  wr_d = '0;
  logic [NP-1:0]         req_read_ready, req_write_ready, rsp_read_valid;
  logic [W-1:0]          rsp_read_data, ram_read_data, ram_write_data;
  logic                  ram_read_vaild, ram_write_vaild;
  logic [AW-1:0]         ram_read_address, ram_write_address;

  ram_port_arbiter #(.N_PORTS(NP), .WIDTH(W), .DEPTH(D)) dut (
    .clock             (clock),
    .reset             (reset),
    .req_read_valid    (rd_v),
    .req_read_ready    (req_read_ready),
    .req_read_address  (rd_a),
    .rsp_read_valid    (rsp_read_valid),
    .rsp_read_data     (rsp_read_data),
    .req_write_valid   (wr_v),
    .req_write_ready   (req_write_ready),
    .req_write_address (wr_a),
    .req_write_data    (wr_d),
    .ram_read_vaild    (ram_read_vaild),
    .ram_read_address  (ram_read_address),
    .ram_read_data     (ram_read_data),
    .ram_write_vaild   (ram_write_vaild),
    .ram_write_address (ram_write_address),
    .ram_write_data    (ram_write_data)
  );

  always #5 clock = ~clock;

  // External RAM: registered read, garbage when not read.
  logic [W-1:0] ram_mem [D];
  always @(posedge clock) begin
    if (ram_read_vaild) ram_read_data <= ram_mem[ram_read_address];
    else                ram_read_data <= 32'hDEAD_BEEF;
    if (ram_write_vaild) ram_mem[ram_write_address] <= ram_write_data;
  end

  int tests = 0, fails = 0, cyc = 0;
  typedef struct { int port; logic [W-1:0] data; int due; } exp_t;
  exp_t         sb[$];
  int           rd_log[$], wr_log[$];
  logic [W-1:0] rsp_log[$];
  int           rd_last = NP - 1, wr_last = NP - 1;
  logic [W-1:0] mmem [D];
  bit [NP-1:0]  rd_taken = '0, wr_taken = '0;
  bit           wr_hold = 1'b0;

  always @(posedge clock) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NP-1:0] v, input int last);
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (last + k) % NP;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  // Reference model: who should win this cycle, what the RAM should see, what data comes back.
  always @(negedge clock) begin : model
    int rp, wp;
    logic [NP-1:0] er, ew;
    logic [AW:0]   erb;
    logic [AW+W:0] ewb;
    if (!reset) begin
      rp  = pick(rd_v, rd_last);
      wp  = pick(wr_v, wr_last);
      er  = (rp >= 0) ? (NP'(1) << rp) : '0;
      ew  = (wp >= 0) ? (NP'(1) << wp) : '0;
      erb = (rp >= 0) ? {1'b1, rd_a[rp]} : '0;
      ewb = (wp >= 0) ? {1'b1, wr_a[wp], wr_d[wp]} : '0;
      check("rd_grant", req_read_ready, er);
      check("wr_grant", req_write_ready, ew);
      check("ram_rd_drive", {ram_read_vaild, ram_read_address}, erb);
      check("ram_wr_drive", {ram_write_vaild, ram_write_address, ram_write_data}, ewb);
      if (rp >= 0) begin
        sb.push_back('{rp, mmem[rd_a[rp]], cyc + 1});
        rd_last = rp; rd_taken[rp] = 1'b1; rd_log.push_back(rp);
      end
      if (wp >= 0) begin
        mmem[wr_a[wp]] = wr_d[wp];
        wr_last = wp; wr_taken[wp] = 1'b1; wr_log.push_back(wp);
      end
    end
  end

  always @(posedge reset) begin
    sb.delete();
    rd_last = NP - 1;
    wr_last = NP - 1;
  end

  always @(negedge clock) begin : monitor
    exp_t e;
    #1;
    if (rsp_read_valid != '0) begin
      rsp_log.push_back(rsp_read_data);
      if (sb.size() == 0) check("rsp_unexpected", rsp_read_valid, 0);
      else begin
        e = sb.pop_front();
        check("rsp_port", rsp_read_valid, NP'(1) << e.port);
        check("rsp_data", rsp_read_data, e.data);
      end
    end else begin
      check("rsp_idle_data", rsp_read_data, 0);
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("rsp_missing", rsp_read_valid, NP'(1) << e.port);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (rd_taken[p]) begin rd_taken[p] = 1'b0; rd_v[p] = 1'b0; end
      if (wr_taken[p]) begin wr_taken[p] = 1'b0; if (!wr_hold) wr_v[p] = 1'b0; end
    end
  endtask

  task automatic preload(input int a, input logic [W-1:0] v);
    ram_mem[a] = v;
    mmem[a]    = v;
  endtask

  initial begin
    int saved, cnt0;
    for (int i = 0; i < D; i++) preload(i, $urandom);
    for (int i = 1; i <= 4; i++) preload(i, W'(32'hA0 + i));

    // Reset state with everyone requesting.
    rd_v = '1; wr_v = '1;
    @(negedge clock); #2;
    check("rst_ready", {req_read_ready, req_write_ready}, 0);
    check("rst_ram_vaild", {ram_read_vaild, ram_write_vaild}, 0);
    check("rst_rsp", {rsp_read_valid, rsp_read_data}, 0);
    rd_v = '0; wr_v = '0;
    @(posedge clock); #1;
    reset = 1'b0;

    // Four simultaneous reads drain 0,1,2,3 and return A1..A4.
    rd_log.delete(); rsp_log.delete();
    rd_v = '1;
    for (int p = 0; p < NP; p++) rd_a[p] = AW'(p + 1);
    repeat (5) tick();
    check("rd_order_len", rd_log.size(), 4);
    check("rsp_order_len", rsp_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < rd_log.size())  check("rd_order", rd_log[k], k);
      if (k < rsp_log.size()) check("rsp_preload", rsp_log[k], 32'hA1 + k);
    end

    // Held write requests rotate evenly.
    wr_log.delete(); wr_hold = 1'b1; wr_v = '1;
    for (int p = 0; p < NP; p++) begin wr_a[p] = AW'(6 + p % 2); wr_d[p] = $urandom; end
    repeat (8) tick();
    wr_v = '0; wr_hold = 1'b0; wr_taken = '0;
    check("wr_hold_len", wr_log.size(), 8);
    cnt0 = 0;
    for (int k = 0; k < wr_log.size(); k++) begin
      check("wr_hold_order", wr_log[k], k % NP);
      if (wr_log[k] == 0) cnt0++;
    end
    check("wr_port0_twice", cnt0, 2);

    // Pointer after port 2: ports 1 and 3 -> 3 then 1.
    rd_log.delete();
    rd_v = 4'b0100; rd_a[2] = 3'd0;
    tick();
    rd_v = 4'b1010; rd_a[1] = 3'd2; rd_a[3] = 3'd3;
    tick(); tick();
    check("rr_len", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      check("rr_first", rd_log[1], 3);
      check("rr_second", rd_log[2], 1);
    end

    // Same-cycle read/write to one address returns old data.
    tick();
    preload(5, 32'h11);
    rsp_log.delete();
    wr_v[0] = 1'b1; wr_a[0] = 3'd5; wr_d[0] = 32'h55;
    rd_v[1] = 1'b1; rd_a[1] = 3'd5;
    tick();
    rd_v[2] = 1'b1; rd_a[2] = 3'd5;
    tick(); tick();
    check("rw_len", rsp_log.size(), 2);
    if (rsp_log.size() == 2) begin
      check("rw_old", rsp_log[0], 32'h11);
      check("rw_new", rsp_log[1], 32'h55);
    end

    // Reset lands between a read grant and its response.
    rd_v = 4'b0100; rd_a[2] = 3'd1;
    @(negedge clock); #3;
    reset = 1'b1;
    tick();
    rd_log.delete();
    rd_v = 4'b1010; rd_a[1] = 3'd4; rd_a[3] = 3'd2;
    repeat (2) begin
      @(negedge clock); #2;
      check("rst_drop_rsp", rsp_read_valid, 0);
      check("rst_no_grant", req_read_ready, 0);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    tick(); tick();
    check("post_rst_len", rd_log.size(), 2);
    if (rd_log.size() > 0) check("post_rst_first", rd_log[0], 1);

    // Idle period keeps pointers.
    repeat (10) tick();
    saved = rd_last;
    rd_log.delete();
    rd_v = '1;
    for (int p = 0; p < NP; p++) rd_a[p] = AW'($urandom_range(0, D - 1));
    tick();
    if (rd_log.size() > 0) check("idle_ptr", rd_log[0], (saved + 1) % NP);
    else check("idle_ptr_grant", req_read_ready, 1);
    repeat (4) tick();

    // Randomised traffic.
    repeat (400) begin
      for (int p = 0; p < NP; p++) begin
        if (!rd_v[p] && $urandom_range(0, 1) == 1) begin
          rd_v[p] = 1'b1; rd_a[p] = AW'($urandom_range(0, D - 1));
        end
        if (!wr_v[p] && $urandom_range(0, 2) == 0) begin
          wr_v[p] = 1'b1; wr_a[p] = AW'($urandom_range(0, D - 1)); wr_d[p] = $urandom;
        end
      end
      tick();
    end
    rd_v = '0; wr_v = '0;
    repeat (4) tick();
    for (int i = 0; i < D; i++) check("final_mem", ram_mem[i], mmem[i]);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
